trail_writer: RTL and testbench

Frame-buffer writer that paints the light-cycle trails into `frameRAM` and is the producing end of the port pair whose consuming end is the display read path. The display read path fetches one 16-bit word per pixel pair at `DrawX/2 + DrawY*320` and takes nibble [3:0] for even X and nibble [11:8] for odd X. This block generates `write_address`, the write data and `WE` for the same RAM. It wipes the buffer after reset or on request, then writes both bikes' current positions once per `frame_clk` tick.

---
 rtl/tron_pkg.sv | 28 ++
 rtl/trail_writer_if.sv | 22 ++
 rtl/trail_writer_pulse_sync.sv | 28 ++
 rtl/trail_writer.sv | 150 +++++++++++++++
 tb/tb_trail_writer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tron_pkg.sv
// Shared types and constants for the light-cycle frame-buffer path.
// Colors, word packing and the trail writer's state encoding live here.
package tron_pkg;

    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 16;
    localparam int H_WORDS  = 320;
    localparam int FB_WORDS = 153600;

    typedef enum logic [3:0] {
        COL_BG         = 4'h0,
        COL_RED_TRAIL  = 4'h4,
        COL_BLUE_TRAIL = 4'h6
    } color_e;

    typedef enum logic [1:0] {
        CLEAR,
        WAIT,
        WR_BLUE,
        WR_RED
    } tw_state_t;

    // Both pixels of a word share the color; the high nibbles stay dark.
    function automatic logic [DATA_W-1:0] pack_word(color_e c);
        return {4'h0, c, 4'h0, c};
    endfunction

endpackage

// File: rtl/trail_writer_if.sv
// Frame-buffer write port: the writer drives it, frameRAM consumes it.
// No handshake: the RAM accepts a write every cycle.
interface trail_writer_if;
    import tron_pkg::*;

    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_data;
    logic              WE;

    modport master (
        output write_address,
        output write_data,
        output WE
    );

    modport slave (
        input write_address,
        input write_data,
        input WE
    );

endinterface

// File: rtl/trail_writer_pulse_sync.sv
// Two-flop synchronizer for the frame tick plus a rising-edge detector.
// The pulse is one Clk cycle wide, 2-3 cycles after the async rise.
module pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= async_in;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign pulse = sync2 & ~sync2_d;

endmodule

// File: rtl/trail_writer.sv
// Paints both bikes' trail rows into frameRAM once per frame tick,
// and wipes the whole buffer after reset or on a new-round request.
module trail_writer #(
    parameter int TRAIL_ROWS = 2,
    parameter int H_WORDS    = 320,
    parameter int V_LINES    = 480
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           frame_clk,
    input  logic           clear_req,
    input  logic           blue_en,
    input  logic           red_en,
    input  logic [9:0]     Blue_X_real,
    input  logic [9:0]     Blue_Y_real,
    input  logic [9:0]     Red_X_real,
    input  logic [9:0]     Red_Y_real,
    trail_writer_if.master wr,
    output logic           busy,
    output logic           clear_done
);
    import tron_pkg::*;

    localparam int CLR_LAST = H_WORDS * V_LINES - 1;
    localparam int CW       = $clog2(H_WORDS * V_LINES);

    logic            tick;
    tw_state_t       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [9:0]      bx, by, rx, ry;
    logic            ben, ren;
    logic            snap;
    logic [18:0]     addr_n;
    logic [15:0]     data_n;
    logic            we_n;
    logic            wipe_last, wipe_last_n;

    logic [9:0]      cur_x, cur_y;
    logic            cur_en;
    logic [18:0]     row_y;
    logic            row_ok;
    logic            last_row;

    pulse_sync u_sync (
        .clk      (Clk),
        .rst      (Reset),
        .async_in (frame_clk),
        .pulse    (tick)
    );

    assign cur_x    = (state == WR_RED) ? rx : bx;
    assign cur_y    = (state == WR_RED) ? ry : by;
    assign cur_en   = (state == WR_RED) ? ren : ben;
    assign row_y    = 19'(cur_y) + 19'(cnt);
    assign row_ok   = cur_en && (cur_x < 10'd640)
                   && (row_y < 19'(V_LINES));
    assign last_row = (cnt == CW'(TRAIL_ROWS - 1));

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        addr_n      = '0;
        data_n      = '0;
        we_n        = 1'b0;
        snap        = 1'b0;
        wipe_last_n = 1'b0;
        unique case (state)
            CLEAR: begin
                we_n   = 1'b1;
                addr_n = 19'(cnt);
                data_n = pack_word(COL_BG);
                if (cnt == CW'(CLR_LAST)) begin
                    state_n     = WAIT;
                    cnt_n       = '0;
                    wipe_last_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT: begin
                if (tick) begin
                    snap    = 1'b1;
                    state_n = WR_BLUE;
                    cnt_n   = '0;
                end
            end
            WR_BLUE, WR_RED: begin
                // Skipped rows still burn their cycle to keep latency fixed.
                we_n   = row_ok;
                addr_n = 19'(cur_x[9:1]) + row_y * 19'(H_WORDS);
                data_n = pack_word((state == WR_BLUE) ?
                                   COL_BLUE_TRAIL : COL_RED_TRAIL);
                if (last_row) begin
                    cnt_n   = '0;
                    state_n = (state == WR_BLUE) ? WR_RED : WAIT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: ;
        endcase
        if (clear_req) begin
            state_n     = CLEAR;
            cnt_n       = '0;
            snap        = 1'b0;
            wipe_last_n = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state            <= CLEAR;
            cnt              <= '0;
            wr.write_address <= '0;
            wr.write_data    <= '0;
            wr.WE            <= 1'b0;
            busy             <= 1'b1;
            clear_done       <= 1'b0;
            wipe_last        <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            wr.write_address <= addr_n;
            wr.write_data    <= data_n;
            wr.WE            <= we_n;
            busy             <= (state != WAIT);
            wipe_last        <= wipe_last_n;
            clear_done       <= wipe_last;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bx  <= '0;
            by  <= '0;
            rx  <= '0;
            ry  <= '0;
            ben <= 1'b0;
            ren <= 1'b0;
        end else if (snap) begin
            bx  <= Blue_X_real;
            by  <= Blue_Y_real;
            rx  <= Red_X_real;
            ry  <= Red_Y_real;
            ben <= blue_en;
            ren <= red_en;
        end
    end

endmodule

// File: tb/tb_trail_writer.sv
// Bench for trail_writer: a per-edge schedule of expected writes is built
// from the painting rules and compared against the DUT every cycle.
module tb_trail_writer;

    localparam int ROWS = 2;
    localparam int HW   = 320;
    localparam int VL   = 40;
    localparam int W    = HW * VL;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       clear_req = 1'b0;
    logic       blue_en = 1'b0;
    logic       red_en = 1'b0;
    logic [9:0] bx = '0, by = '0, rx = '0, ry = '0;
    logic       busy, clear_done;

    trail_writer_if wr ();

    trail_writer #(
        .TRAIL_ROWS (ROWS),
        .H_WORDS    (HW),
        .V_LINES    (VL)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .clear_req   (clear_req),
        .blue_en     (blue_en),
        .red_en      (red_en),
        .Blue_X_real (bx),
        .Blue_Y_real (by),
        .Red_X_real  (rx),
        .Red_Y_real  (ry),
        .wr          (wr),
        .busy        (busy),
        .clear_done  (clear_done)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int chk_from = 0;
    int idle_at = 0;
    int hi_key = 0;
    int fc_low_at = 0;

    // Expected outputs keyed by the posedge index that registers them.
    logic [34:0] exp_wr [int];
    bit          exp_busy [int];
    bit          exp_done [int];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h want %0h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] word(logic [3:0] c);
        return {4'h0, c, 4'h0, c};
    endfunction

    function automatic logic [34:0] getw(int k);
        return (exp_wr.exists(k) != 0) ? exp_wr[k] : 35'd0;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic sched_wipe(int s);
        for (int i = 0; i < W; i++) begin
            exp_wr[s + 1 + i]   = {19'(i), 16'h0000};
            exp_busy[s + 1 + i] = 1'b1;
        end
        exp_done[s + W + 1] = 1'b1;
        idle_at = s + W;
        if (s + W + 1 > hi_key) hi_key = s + W + 1;
    endtask

    task automatic model_clear(int c);
        for (int k = c + 1; k <= hi_key; k++) begin
            if (exp_wr.exists(k) != 0) exp_wr.delete(k);
            if (exp_busy.exists(k) != 0) exp_busy.delete(k);
            if (exp_done.exists(k) != 0) exp_done.delete(k);
        end
        sched_wipe(c);
    endtask

    task automatic sched_frame(int t, int x0, int y0, int x1, int y1,
                               bit e0, bit e1);
        int x, y, k, yy;
        bit en;
        for (int b = 0; b < 2; b++) begin
            x  = (b == 0) ? x0 : x1;
            y  = (b == 0) ? y0 : y1;
            en = (b == 0) ? e0 : e1;
            for (int r = 0; r < ROWS; r++) begin
                k  = t + 1 + b * ROWS + r;
                yy = y + r;
                exp_busy[k] = 1'b1;
                if (en && x < 640 && yy < VL)
                    exp_wr[k] = {19'(x / 2 + yy * HW),
                                 word((b == 0) ? 4'h6 : 4'h4)};
            end
        end
        idle_at = t + 2 * ROWS;
        if (idle_at > hi_key) hi_key = idle_at;
    endtask

    task automatic do_tick(int x0, int y0, int x1, int y1, bit e0, bit e1,
                           bit clr, int gap, output bit acc, output int t);
        if (cyc <= fc_low_at) step();
        bx = 10'(x0);
        by = 10'(y0);
        rx = 10'(x1);
        ry = 10'(y1);
        blue_en = e0;
        red_en = e1;
        frame_clk = 1'b1;
        t = cyc + 3;
        acc = !clr && (idle_at <= t - 1);
        if (clr) model_clear(t);
        if (acc) sched_frame(t, x0, y0, x1, y1, e0, e1);
        step();
        step();
        if (clr) clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        frame_clk = 1'b0;
        fc_low_at = cyc;
        bx = 10'($urandom_range(0, 1023));
        by = 10'($urandom_range(0, 1023));
        rx = 10'($urandom_range(0, 1023));
        ry = 10'($urandom_range(0, 1023));
        blue_en = 1'($urandom_range(0, 1));
        red_en = 1'($urandom_range(0, 1));
        repeat (gap) step();
    endtask

    task automatic do_clear();
        model_clear(cyc + 1);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc < idle_at + 3) step();
    endtask

    always @(negedge Clk) begin
        logic [37:0] act, expv;
        logic        we_e;
        if (chk_from > 0 && cyc >= chk_from) begin
            we_e = (exp_wr.exists(cyc) != 0);
            expv = {we_e, getw(cyc), exp_busy.exists(cyc) != 0,
                    exp_done.exists(cyc) != 0};
            act  = {wr.WE,
                    wr.WE ? {wr.write_address, wr.write_data} : 35'd0,
                    busy, clear_done};
            check("cycle{we,addr,data,busy,done}", 64'(act), 64'(expv));
        end
    end

    always @(posedge Clk) begin
        if (cyc > 90000) begin
            $display("FAIL watchdog: cycle budget exceeded at edge %0d", cyc);
            $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
            $fatal(1);
        end
    end

    initial begin
        bit acc;
        int t, r, x0, y0, x1, y1, gap;
        bit e0, e1;

        repeat (3) step();
        check("rst_we", 64'(wr.WE), 64'd0);
        check("rst_addr", 64'(wr.write_address), 64'd0);
        check("rst_data", 64'(wr.write_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_done", 64'(clear_done), 64'd0);
        Reset = 1'b0;
        r = cyc;
        sched_wipe(r);
        chk_from = r + 1;
        check("pin_wipe_first", 64'(getw(r + 1)), 64'd0);
        check("pin_wipe_last", 64'(getw(r + W)), {29'd0, 19'd12799, 16'h0});
        check("pin_wipe_done", 64'(exp_done.exists(r + W + 1)), 64'd1);
        wait_idle();

        do_tick(100, 30, 301, 10, 1, 1, 0, 0, acc, t);
        check("pin_acc", 64'(acc), 64'd1);
        check("pin_blue0", 64'(getw(t + 1)), {29'd0, 19'd9650, 16'h0606});
        check("pin_blue1", 64'(getw(t + 2)), {29'd0, 19'd9970, 16'h0606});
        check("pin_red0", 64'(getw(t + 3)), {29'd0, 19'd3350, 16'h0404});
        check("pin_red1", 64'(getw(t + 4)), {29'd0, 19'd3670, 16'h0404});
        wait_idle();

        do_tick(100, 30, 301, 10, 1, 0, 0, 0, acc, t);
        check("pin_red_off", 64'(exp_wr.exists(t + 3) + exp_wr.exists(t + 4)),
              64'd0);
        check("pin_busy_len", 64'(exp_busy.exists(t + 4) != 0 &&
                                  exp_busy.exists(t + 5) == 0), 64'd1);
        wait_idle();

        do_tick(10, 39, 0, 0, 1, 0, 0, 0, acc, t);
        check("pin_bottom_row0", 64'(getw(t + 1)),
              {29'd0, 19'd12485, 16'h0606});
        check("pin_bottom_row1", 64'(exp_wr.exists(t + 2)), 64'd0);
        wait_idle();

        do_tick(640, 5, 639, 5, 1, 1, 0, 0, acc, t);
        check("pin_x640", 64'(exp_wr.exists(t + 1)), 64'd0);
        check("pin_x639", 64'(getw(t + 3)), {29'd0, 19'd1919, 16'h0404});
        wait_idle();

        do_tick(100, 30, 301, 10, 1, 1, 0, 0, acc, t);
        do_clear();
        check("pin_abort_blue", 64'(getw(t + 1)), {29'd0, 19'd9650, 16'h0606});
        check("pin_abort_wipe0", 64'(getw(t + 2)), 64'd0);
        check("pin_abort_wipe1", 64'(getw(t + 3)), {29'd0, 19'd1, 16'h0});

        repeat (20) step();
        do_tick(50, 5, 60, 6, 1, 1, 0, 2, acc, t);
        check("pin_tick_in_clear", 64'(acc), 64'd0);
        repeat (30) step();
        do_clear();
        while (cyc < idle_at + 1) step();
        do_tick(200, 20, 400, 21, 1, 1, 0, 0, acc, t);
        check("pin_tick_after_done", 64'(acc), 64'd1);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            x0 = $urandom_range(0, 700);
            y0 = $urandom_range(0, 45);
            x1 = $urandom_range(0, 700);
            y1 = $urandom_range(0, 45);
            e0 = ($urandom_range(0, 9) != 0);
            e1 = ($urandom_range(0, 9) != 0);
            gap = $urandom_range(0, 6);
            do_tick(x0, y0, x1, y1, e0, e1, 0, gap, acc, t);
        end
        wait_idle();

        do_tick(120, 12, 130, 13, 1, 1, 1, 0, acc, t);
        check("pin_clear_wins", 64'(acc), 64'd0);
        wait_idle();
        do_tick(300, 3, 310, 4, 1, 1, 0, 0, acc, t);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
